// File: rtl/cpuc_mul_seq.sv
// ---------------------------------------------------------------------------
// cpuc_mul_seq
//
// Multi-cycle iterative multiplier for the CPUC execute stage. It computes the
// full 2*WIDTH-bit product of two WIDTH-bit operands with a shift-add loop.
// The loop retires BITS_PER_CYCLE multiplier bits per cycle, so one operation
// takes N_ITER = WIDTH/BITS_PER_CYCLE compute cycles. Each operand can be
// treated as signed or unsigned, and either half of the product can be
// returned. Together these cover MUL, MULH, MULHSU and MULHU.
//
// The loop works on operand magnitudes only. The product sign is applied once,
// at the end, by taking the two's complement of the 2W-bit accumulator.
//
// Ports:
//   Clk        clock; all state changes on the rising edge
//   Rst        synchronous active-high reset
//   in_valid   operands and mode are valid
//   in_ready   block can accept an operation (IDLE only)
//   op_a       multiplicand
//   op_b       multiplier
//   a_signed   treat op_a as two's complement
//   b_signed   treat op_b as two's complement
//   high_sel   1: return product[2W-1:W], 0: return product[W-1:0]
//   out_valid  result is valid (DONE state)
//   out_ready  consumer accepts the result
//   result     selected product half; held until the next result or reset
//   busy       an operation is in flight (state != IDLE)
//
// BITS_PER_CYCLE must divide WIDTH. Legal values are 1, 2, 4 and 8.
// ---------------------------------------------------------------------------
module cpuc_mul_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             a_signed,
    input  logic             b_signed,
    input  logic             high_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int N_ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int PW     = 2 * WIDTH;
    localparam int SH_W   = $clog2(PW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_mag_q;     // |op_a|
    logic [WIDTH-1:0]   b_shift_q;   // |op_b|, shifted right each cycle
    logic [PW-1:0]      acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;       // final product must be negated
    logic               high_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   result_q;

    // Operand magnitudes are taken at accept time. The most negative value
    // negates to itself, and that bit pattern is exactly 2^(W-1) read as
    // unsigned, so it needs no special case.
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;

    assign a_neg    = a_signed & op_a[WIDTH-1];
    assign b_neg    = b_signed & op_b[WIDTH-1];
    assign a_mag_in = a_neg ? -op_a : op_a;
    assign b_mag_in = b_neg ? -op_b : op_b;

    // Partial products for the current multiplier digit: one shifted copy of
    // |a| for each set bit of the digit.
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [PW-1:0]             pp [BITS_PER_CYCLE];

    assign digit = b_shift_q[BITS_PER_CYCLE-1:0];

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = digit[gi] ? (PW'(a_mag_q) << gi) : '0;
        end
    endgenerate

    logic [PW-1:0]   pp_sum;
    logic [SH_W-1:0] shamt;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   prod_d;
    logic            last_iter;

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            pp_sum = pp_sum + pp[i];
        end
        // The digit weight is cnt*BPC. Its maximum is W-BPC, which always
        // fits in SH_W bits.
        shamt     = SH_W'(cnt_q) * SH_W'(BITS_PER_CYCLE);
        acc_d     = acc_q + (pp_sum << shamt);
        // On the last iteration, the sign is applied to the finished
        // accumulator in the same cycle. The result is therefore registered
        // on the final CALC edge.
        prod_d    = neg_q ? -acc_d : acc_d;
        last_iter = (cnt_q == CNT_W'(N_ITER - 1));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            a_mag_q     <= '0;
            b_shift_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            high_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready_q is always 1 here, so in_valid alone
                    // completes the handshake.
                    if (in_valid) begin
                        a_mag_q    <= a_mag_in;
                        b_shift_q  <= b_mag_in;
                        neg_q      <= a_neg ^ b_neg;
                        high_q     <= high_sel;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end
                end

                S_CALC: begin
                    acc_q     <= acc_d;
                    b_shift_q <= b_shift_q >> BITS_PER_CYCLE;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        result_q    <= high_q ? prod_d[PW-1:WIDTH] : prod_d[WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end

                S_DONE: begin
                    // result_q keeps its value after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: doc/cpuc_mul_seq.md
Name: cpuc_mul_seq

Overview:
Parametrised, multi-cycle iterative multiplier replacing the single-cycle combinational multiply in the CPUC execute path. It accepts two operands through a valid/ready handshake. It computes the full 2*WIDTH-bit product using a radix-2^BITS_PER_CYCLE shift-add loop. It supports signed/unsigned operand selection and low/high result selection, covering RISC-V MUL/MULH/MULHSU/MULHU. The result is returned through a second valid/ready handshake, so the pipeline can stall on it.

Parameters:
WIDTH, DATA_WIDTH (from cpuc_package), operand and result width in bits.
BITS_PER_CYCLE, 1, multiplier bits retired per compute cycle. Must divide WIDTH; legal values are 1, 2, 4 and 8.
(derived) N_ITER = WIDTH/BITS_PER_CYCLE, number of compute cycles.

Ports:
Clk  in  1  clock, all state updates on the rising edge
Rst  in  1  synchronous active-high reset
in_valid  in  1  operands and mode are valid
in_ready  out  1  block can accept an operation
op_a  in  WIDTH  multiplicand
op_b  in  WIDTH  multiplier
a_signed  in  1  treat op_a as two's complement
b_signed  in  1  treat op_b as two's complement
high_sel  in  1  1 = return product[2W-1:W]; 0 = return product[W-1:0]
out_valid  out  1  result is valid
out_ready  in  1  consumer accepts the result
result  out  WIDTH  selected product half
busy  out  1  an operation is in flight (state != IDLE)

Behaviour:
- Clocking and reset: one clock, Clk. Rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0. All internal accumulators are cleared.
- Reset mid-operation: on the next edge the in-flight operation is discarded. No out_valid is produced for it, and the block returns to IDLE.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - An accept occurs when in_valid && in_ready at an edge. On accept, latch |op_a| and |op_b| (magnitudes after conditional negation when the signed flag is set and the MSB is 1). Also latch the result sign = (a_signed&op_a[W-1]) ^ (b_signed&op_b[W-1]) and latch high_sel. Clear the accumulator and the iteration counter, then go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: add |a| * (low BITS_PER_CYCLE bits of the multiplier) into the 2W-bit accumulator at the current shift position, shift the multiplier right by BITS_PER_CYCLE, and increment the counter.
  - After N_ITER cycles, apply the sign: if the sign is set, the product is the two's complement of the 2W-bit accumulator.
  - Register result = high_sel ? product[2W-1:W] : product[W-1:0], then go to DONE.
- DONE:
  - out_valid=1 and result is held stable until out_ready.
  - On out_valid && out_ready: go to IDLE and drop out_valid. result keeps its last value and is not cleared.
- Latency: accept at edge E, out_valid asserted from the cycle after edge E+N_ITER. The first result is visible N_ITER+1 cycles after the accept cycle.
- Throughput: one operation per N_ITER+2 cycles with out_ready tied to 1. There is no overlap of consecutive operations.
- in_valid is ignored when in_ready=0. The upstream must hold op_a/op_b/mode stable until accepted; these inputs are not sampled after the accept edge.
- Arithmetic:
  - The full product is computed exactly in 2W bits, so there is no overflow at any stage.
  - Magnitude of the most negative operand (0x80..0 signed) is 2^(W-1), which is representable in the unsigned W-bit magnitude register.
  - A zero operand takes the full N_ITER cycles; there is no early termination.
- Simultaneous events: Rst dominates in_valid and out_ready. out_ready while in IDLE or CALC has no effect.

Test Plan:
- WIDTH=32, BPC=1, out_ready=1; op_a=7, op_b=6, unsigned, high_sel=0. Required: result=42, out_valid exactly 33 cycles after the accept cycle, in_ready low in between.
- Signed/signed, high_sel=0 then 1, op_a=op_b=0xFFFFFFFF. Required: low=0x00000001, high=0x00000000. Then 0x80000000*0x80000000 signed, high. Required: 0x40000000, low 0x00000000.
- MULHSU: a_signed=1, b_signed=0, op_a=0xFFFFFFFE, op_b=3, high_sel=1. Required: 0xFFFFFFFF. MULHU: 0xFFFFFFFF*0xFFFFFFFF, high. Required: 0xFFFFFFFE.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_valid and result stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 → IDLE next cycle and in_ready=1.
- Reset mid-CALC: assert Rst at iteration 15 for one cycle. Required: next cycle IDLE, out_valid=0, result=0, no spurious result. The following op 3*5 returns 15.
- BPC=4 build: random signed/unsigned/high/low operands checked against a reference 64-bit model. Required: bit-exact match, latency exactly 9 cycles.
